exunit_alu_pipe: RTL and testbench
==================================

Name: exunit_alu_pipe

Overview:
- Parametrised integer ALU execution unit with configurable pipeline latency, tag carry-through and a result buffer.
- Adds a valid/ready writeback handshake and credit-based backpressure via o_inaccessable.
- Sits between the ALU reservation station (issue side) and the CDB/ROB writeback arbiter.
- With LAT=1 and an always-ready writeback, timing matches a single-cycle ALU unit: o_exfin one cycle after issue.

Parameters:
- DATA_W, 32, operand/result/PC width.
- TAG_W, 6, destination tag width, carried unmodified to output.
- LAT, 1, pipeline stages from issue to result-buffer write; legal 1..4.
- DEPTH, 2, result buffer entries and issue credits; legal 1..8; full throughput needs DEPTH >= LAT+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, active-low.
- o_inaccessable  out  1  issue not accepted this cycle.
- i_is_vld  in  1  issue valid.
- i_op_sel  in  4  ALU op.
- i_src1_sel  in  2  src1 select.
- i_src2_sel  in  2  src2 select.
- i_rs1  in  DATA_W  operand.
- i_pc  in  DATA_W  operand.
- i_rs2  in  DATA_W  operand.
- i_imm  in  DATA_W  operand.
- i_tag  in  TAG_W  destination tag.
- i_kill  in  1  flush all in-flight and buffered work.
- o_exfin  out  1  result valid (buffer head).
- o_exfin_res  out  DATA_W  result.
- o_exfin_tag  out  TAG_W  tag.
- i_exfin_rdy  in  1  writeback accepts head.

Behaviour:
- Clock/reset: single clock clk; reset rst_n is synchronous, active-low, sampled at posedge.
- Reset: all stage valids, buffer pointers and credit count cleared. o_exfin=0, o_inaccessable=0, o_exfin_res=0, o_exfin_tag=0.
- src1 select: 0=rs1, 1=pc, 2=0, 3=0.
- src2 select: 0=rs2, 1=imm, 2=4, 3=0.
- ALU ops: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS src2; 11-15 give 0.
  - Shift amount is src2[log2(DATA_W)-1:0].
  - SLT/SLTU give 0/1 zero-extended.
  - All arithmetic wraps modulo 2^DATA_W.
- Accept: issue accepted when i_is_vld && !o_inaccessable. While o_inaccessable=1, i_is_vld is ignored (bench asserts it never happens).
- Pipeline: the result is computed in stage 0 and shifted through LAT stages with its tag. Stages never stall; each stage has a valid bit.
- Result buffer: FIFO of DEPTH entries, written when the last stage is valid.
  - Head drives o_exfin/o_exfin_res/o_exfin_tag.
  - Pop when o_exfin && i_exfin_rdy.
  - Head data holds stable while o_exfin=1 and not popped.
- Credits: count = accepted-not-popped ops, 0..DEPTH.
  - +1 on accept, -1 on pop; simultaneous accept and pop leaves count unchanged.
  - o_inaccessable = (count == DEPTH), combinational from the registered count. It does not consider a same-cycle pop.
  - Credits guarantee the FIFO can never overflow.
- Latency: op accepted in cycle t is presented on o_exfin at cycle t+LAT at the earliest (empty buffer). Back-to-back ops retire in order, one per cycle when ready.
- Kill: i_kill=1 at posedge clears all stage valids, FIFO pointers and count.
  - Next cycle: o_exfin=0, o_inaccessable=0.
  - Issue in the same cycle as i_kill is discarded.
  - Kill has priority over accept and pop.
- Reset mid-operation: identical to kill.
- Wrap-around: FIFO pointers wrap modulo DEPTH; full/empty are derived from count, not pointer equality.

Test Plan:
- LAT=1, DEPTH=2, rdy=1: issue ADD rs1=5, rs2=7, tag=3 at cycle 0 -> o_exfin=1, res=12, tag=3 at cycle 1 only.
- Ops sweep, DATA_W=32:
  - SUB 0-1 -> 0xFFFFFFFF.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLT -1<1 -> 1; SLTU -1<1 -> 0.
  - src1_sel=1, pc=0x100, src2_sel=2 -> 0x104.
- LAT=3, DEPTH=4, rdy=1: issue 4 ops on consecutive cycles 0-3 -> results at cycles 3-6 in order; o_inaccessable never 1.
- LAT=2, DEPTH=2, rdy=0: issue at cycles 0 and 1 -> o_inaccessable=1 from cycle 2. Head holds the op-0 result stable. Raise rdy at cycle 5 -> pops at cycles 5 and 6; o_inaccessable=0 at cycle 6.
- Kill with 2 ops in flight and 1 buffered -> next cycle o_exfin=0, count=0. No stale result appears for the next 6 cycles.
- rst_n=0 for 1 cycle mid-stream -> all outputs 0 the following cycle; a fresh issue completes with correct latency.

Source files
------------

// File: rtl/exunit_alu_pipe.sv
// -----------------------------------------------------------------------------
// exunit_alu_pipe
//   Integer ALU execution unit. The result is computed combinationally in the
//   issue cycle (stage 0), carried with its tag through LAT-1 registered stages
//   and written into a DEPTH-entry result FIFO. The FIFO head is offered to the
//   writeback arbiter over a valid/ready handshake. Issue credits (one per
//   accepted-but-not-popped op) throttle the reservation station so the FIFO
//   can never overflow.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   o_inaccessable    1 = issue not accepted this cycle (all credits in use)
//   i_is_vld          issue valid
//   i_op_sel          ALU op (0 ADD .. 10 PASS src2, 11-15 -> 0)
//   i_src1_sel        src1: 0 rs1, 1 pc, 2/3 zero
//   i_src2_sel        src2: 0 rs2, 1 imm, 2 constant 4, 3 zero
//   i_rs1/i_pc/i_rs2/i_imm   operands
//   i_tag             destination tag, carried unmodified
//   i_kill            flush all in-flight and buffered work
//   o_exfin           result valid (FIFO head)
//   o_exfin_res/tag   head result and tag (0 when o_exfin=0)
//   i_exfin_rdy       writeback accepts head this cycle
// -----------------------------------------------------------------------------
module exunit_alu_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int LAT    = 1,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_inaccessable,
    input  logic              i_is_vld,
    input  logic [3:0]        i_op_sel,
    input  logic [1:0]        i_src1_sel,
    input  logic [1:0]        i_src2_sel,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_kill,
    output logic              o_exfin,
    output logic [DATA_W-1:0] o_exfin_res,
    output logic [TAG_W-1:0]  o_exfin_tag,
    input  logic              i_exfin_rdy
);

    localparam int SHW = $clog2(DATA_W);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reset and kill have identical effect and both win over accept/pop.
    logic clr;
    assign clr = !rst_n || i_kill;

    logic [CW-1:0] cred_q, cred_d;
    logic          accept;

    assign o_inaccessable = (cred_q == CW'(DEPTH));
    assign accept         = i_is_vld && !o_inaccessable;

    // ---------------------------------------------------------------- stage 0
    logic [DATA_W-1:0] src1, src2, alu_res;
    logic [SHW-1:0]    shamt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements leaves it unassigned (no latch).
        src1 = '0;
        src2 = '0;
        case (i_src1_sel)
            2'd0:    src1 = i_rs1;
            2'd1:    src1 = i_pc;
            default: src1 = '0;
        endcase
        case (i_src2_sel)
            2'd0:    src2 = i_rs2;
            2'd1:    src2 = i_imm;
            2'd2:    src2 = DATA_W'(4);
            default: src2 = '0;
        endcase
    end

    assign shamt = src2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (i_op_sel)
            4'd0:    alu_res = src1 + src2;
            4'd1:    alu_res = src1 - src2;
            4'd2:    alu_res = src1 << shamt;
            4'd3:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
            4'd4:    alu_res = {{(DATA_W-1){1'b0}}, (src1 < src2)};
            4'd5:    alu_res = src1 ^ src2;
            4'd6:    alu_res = src1 >> shamt;
            4'd7:    alu_res = $unsigned($signed(src1) >>> shamt);
            4'd8:    alu_res = src1 | src2;
            4'd9:    alu_res = src1 & src2;
            4'd10:   alu_res = src2;
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------- stages 1..LAT-1
    logic              wr_vld;
    logic [DATA_W-1:0] wr_res;
    logic [TAG_W-1:0]  wr_tag;

    if (LAT == 1) begin : g_nopipe
        // Single-cycle unit: stage 0 writes the FIFO directly.
        assign wr_vld = accept;
        assign wr_res = alu_res;
        assign wr_tag = i_tag;
    end else begin : g_pipe
        logic [LAT-2:0]    vld_q;
        logic [DATA_W-1:0] res_q [LAT-1];
        logic [TAG_W-1:0]  tag_q [LAT-1];

        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples its predecessor's pre-edge value.
            if (clr) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int k = 1; k < LAT - 1; k++) vld_q[k] <= vld_q[k-1];
            end
        end

        // Payload is qualified by vld_q and needs no reset.
        always_ff @(posedge clk) begin
            res_q[0] <= alu_res;
            tag_q[0] <= i_tag;
            for (int k = 1; k < LAT - 1; k++) begin
                res_q[k] <= res_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end

        assign wr_vld = vld_q[LAT-2];
        assign wr_res = res_q[LAT-2];
        assign wr_tag = tag_q[LAT-2];
    end

    // ------------------------------------------------------------ result FIFO
    logic [DATA_W-1:0] mem_res_q [DEPTH];
    logic [TAG_W-1:0]  mem_tag_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     fcnt_q, fcnt_d;
    logic              pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_exfin = (fcnt_q != '0);
    assign pop     = o_exfin && i_exfin_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        cred_d   = cred_q;
        if (wr_vld) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_vld, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
        case ({accept, pop})
            2'b10:   cred_d = cred_q + 1'b1;
            2'b01:   cred_d = cred_q - 1'b1;
            default: cred_d = cred_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            cred_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            cred_q   <= cred_d;
        end
    end

    // NOTE: storage array is deliberately not reset; entries are only read
    // while counted valid and the outputs are masked otherwise.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem_res_q[wr_ptr_q] <= wr_res;
            mem_tag_q[wr_ptr_q] <= wr_tag;
        end
    end

    assign o_exfin_res = o_exfin ? mem_res_q[rd_ptr_q] : '0;
    assign o_exfin_tag = o_exfin ? mem_tag_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_exunit_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_exunit_alu_pipe
//   Directed bench for exunit_alu_pipe. Three instances cover the
//   configurations of interest: A (LAT=1, DEPTH=2), B (LAT=3, DEPTH=4),
//   C (LAT=2, DEPTH=2). Inputs change and outputs are sampled 1 time unit
//   after each rising edge; "cycle t" is the interval ending at edge t+1.
// -----------------------------------------------------------------------------
module tb_exunit_alu_pipe;

    localparam int DW = 32;
    localparam int TW = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------------------------------------------------- instance A
    logic          inacc_a, vld_a, kill_a, exfin_a, rdy_a;
    logic [3:0]    op_a;
    logic [1:0]    s1_a, s2_a;
    logic [DW-1:0] rs1_a, pc_a, rs2_a, imm_a, res_a;
    logic [TW-1:0] tag_a, otag_a;

    exunit_alu_pipe #(.DATA_W(DW), .TAG_W(TW), .LAT(1), .DEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .o_inaccessable(inacc_a), .i_is_vld(vld_a),
        .i_op_sel(op_a), .i_src1_sel(s1_a), .i_src2_sel(s2_a),
        .i_rs1(rs1_a), .i_pc(pc_a), .i_rs2(rs2_a), .i_imm(imm_a), .i_tag(tag_a),
        .i_kill(kill_a), .o_exfin(exfin_a), .o_exfin_res(res_a),
        .o_exfin_tag(otag_a), .i_exfin_rdy(rdy_a));

    // ---------------------------------------------------------- instance B
    logic          inacc_b, vld_b, kill_b, exfin_b, rdy_b;
    logic [DW-1:0] rs1_b, rs2_b, res_b;
    logic [TW-1:0] tag_b, otag_b;

    exunit_alu_pipe #(.DATA_W(DW), .TAG_W(TW), .LAT(3), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .o_inaccessable(inacc_b), .i_is_vld(vld_b),
        .i_op_sel(4'd0), .i_src1_sel(2'd0), .i_src2_sel(2'd0),
        .i_rs1(rs1_b), .i_pc('0), .i_rs2(rs2_b), .i_imm('0), .i_tag(tag_b),
        .i_kill(kill_b), .o_exfin(exfin_b), .o_exfin_res(res_b),
        .o_exfin_tag(otag_b), .i_exfin_rdy(rdy_b));

    // ---------------------------------------------------------- instance C
    logic          inacc_c, vld_c, exfin_c, rdy_c;
    logic [DW-1:0] rs1_c, rs2_c, res_c;
    logic [TW-1:0] tag_c, otag_c;

    exunit_alu_pipe #(.DATA_W(DW), .TAG_W(TW), .LAT(2), .DEPTH(2)) u_c (
        .clk(clk), .rst_n(rst_n), .o_inaccessable(inacc_c), .i_is_vld(vld_c),
        .i_op_sel(4'd0), .i_src1_sel(2'd0), .i_src2_sel(2'd0),
        .i_rs1(rs1_c), .i_pc('0), .i_rs2(rs2_c), .i_imm('0), .i_tag(tag_c),
        .i_kill(1'b0), .o_exfin(exfin_c), .o_exfin_res(res_c),
        .o_exfin_tag(otag_c), .i_exfin_rdy(rdy_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_vec++;
        if ({exfin_a, inacc_a, res_a, otag_a} !== '0) begin
            n_err++;
            $display("FAIL reset_a: exfin=%b inacc=%b res=%h tag=%h, required all 0",
                     exfin_a, inacc_a, res_a, otag_a);
        end
        n_vec++;
        if ({exfin_b, inacc_b, res_b, otag_b, exfin_c, inacc_c, res_c, otag_c} !== '0) begin
            n_err++;
            $display("FAIL reset_bc: exfin_b=%b inacc_b=%b exfin_c=%b inacc_c=%b, required all 0",
                     exfin_b, inacc_b, exfin_c, inacc_c);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_add();
        op_a = 4'd0; s1_a = 2'd0; s2_a = 2'd0;
        rs1_a = 32'd5; rs2_a = 32'd7; tag_a = 6'd3; vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        n_vec++;
        if (exfin_a !== 1'b1 || res_a !== 32'd12 || otag_a !== 6'd3) begin
            n_err++;
            $display("FAIL single_add: exfin=%b res=%0d tag=%0d, required 1/12/3",
                     exfin_a, res_a, otag_a);
        end
        step();
        n_vec++;
        if (exfin_a !== 1'b0) begin
            n_err++;
            $display("FAIL single_add_once: exfin=%b, required 0", exfin_a);
        end
    endtask

    typedef struct packed {
        logic [3:0]    op;
        logic [1:0]    s1;
        logic [1:0]    s2;
        logic [DW-1:0] rs1;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs2;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp;
    } vec_t;

    task automatic test_ops();
        vec_t v [15];
        v[0]  = '{4'd1,  2'd0, 2'd0, 32'h0,        32'h0,   32'h1,  32'h0,    32'hFFFF_FFFF}; // SUB 0-1
        v[1]  = '{4'd7,  2'd0, 2'd1, 32'h8000_0000, 32'h0,  32'h0,  32'h4,    32'hF800_0000}; // SRA
        v[2]  = '{4'd3,  2'd0, 2'd0, 32'hFFFF_FFFF, 32'h0,  32'h1,  32'h0,    32'h1};         // SLT
        v[3]  = '{4'd4,  2'd0, 2'd0, 32'hFFFF_FFFF, 32'h0,  32'h1,  32'h0,    32'h0};         // SLTU
        v[4]  = '{4'd0,  2'd1, 2'd2, 32'h0,        32'h100, 32'h0,  32'h0,    32'h104};       // pc+4
        v[5]  = '{4'd2,  2'd0, 2'd0, 32'h1,        32'h0,   32'h3F, 32'h0,    32'h8000_0000}; // SLL amt 5 bits
        v[6]  = '{4'd5,  2'd0, 2'd0, 32'hF0F0,     32'h0,   32'hFF00, 32'h0,  32'h0FF0};      // XOR
        v[7]  = '{4'd6,  2'd0, 2'd1, 32'h8000_0000, 32'h0,  32'h0,  32'h4,    32'h0800_0000}; // SRL
        v[8]  = '{4'd8,  2'd0, 2'd0, 32'hF0,       32'h0,   32'h0F, 32'h0,    32'hFF};        // OR
        v[9]  = '{4'd9,  2'd0, 2'd0, 32'hF0,       32'h0,   32'h3C, 32'h0,    32'h30};        // AND
        v[10] = '{4'd10, 2'd0, 2'd1, 32'h1234,     32'h0,   32'h0,  32'hDEAD, 32'hDEAD};      // PASS
        v[11] = '{4'd12, 2'd0, 2'd0, 32'h55,       32'h0,   32'h66, 32'h0,    32'h0};         // illegal op
        v[12] = '{4'd0,  2'd2, 2'd0, 32'h5,        32'h9,   32'h7,  32'h0,    32'h7};         // src1 zero
        v[13] = '{4'd0,  2'd0, 2'd3, 32'h9,        32'h0,   32'h7,  32'h8,    32'h9};         // src2 zero
        v[14] = '{4'd0,  2'd0, 2'd0, 32'hFFFF_FFFF, 32'h0,  32'h2,  32'h0,    32'h1};         // ADD wrap
        for (int i = 0; i < 15; i++) begin
            op_a = v[i].op; s1_a = v[i].s1; s2_a = v[i].s2;
            rs1_a = v[i].rs1; pc_a = v[i].pc; rs2_a = v[i].rs2; imm_a = v[i].imm;
            tag_a = TW'(i); vld_a = 1'b1;
            step();
            vld_a = 1'b0;
            n_vec++;
            if (exfin_a !== 1'b1 || res_a !== v[i].exp || otag_a !== TW'(i)) begin
                n_err++;
                $display("FAIL op_vec%0d: exfin=%b res=%h tag=%0d, required 1/%h/%0d",
                         i, exfin_a, res_a, otag_a, v[i].exp, i);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        rdy_b = 1'b1;
        for (int c = 0; c < 8; c++) begin
            n_vec++;
            if (inacc_b !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_inacc c%0d: inacc=%b, required 0", c, inacc_b);
            end
            n_vec++;
            if (c >= 3 && c <= 6) begin
                if (exfin_b !== 1'b1 || otag_b !== TW'(10 + c - 3) || res_b !== DW'(100 + c - 3)) begin
                    n_err++;
                    $display("FAIL b2b_out c%0d: exfin=%b tag=%0d res=%0d, required 1/%0d/%0d",
                             c, exfin_b, otag_b, res_b, 10 + c - 3, 100 + c - 3);
                end
            end else if (exfin_b !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_idle c%0d: exfin=%b, required 0", c, exfin_b);
            end
            vld_b = (c < 4);
            rs1_b = DW'(c); rs2_b = 32'd100; tag_b = TW'(10 + c);
            step();
        end
        vld_b = 1'b0;
    endtask

    task automatic test_backpressure();
        rdy_c = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) rdy_c = 1'b1;
            n_vec++;
            if (inacc_c !== (c >= 2 && c <= 5)) begin
                n_err++;
                $display("FAIL bp_inacc c%0d: inacc=%b, required %b", c, inacc_c, (c >= 2 && c <= 5));
            end
            n_vec++;
            if (c >= 2 && c <= 6) begin
                if (exfin_c !== 1'b1 || otag_c !== ((c <= 5) ? 6'd20 : 6'd21) ||
                    res_c !== ((c <= 5) ? 32'd50 : 32'd51)) begin
                    n_err++;
                    $display("FAIL bp_head c%0d: exfin=%b tag=%0d res=%0d, required 1/%0d/%0d",
                             c, exfin_c, otag_c, res_c, (c <= 5) ? 20 : 21, (c <= 5) ? 50 : 51);
                end
            end else if (exfin_c !== 1'b0) begin
                n_err++;
                $display("FAIL bp_idle c%0d: exfin=%b, required 0", c, exfin_c);
            end
            vld_c = (c < 2);
            rs1_c = DW'(50 + c); rs2_c = 32'd0; tag_c = TW'(20 + c);
            step();
        end
        vld_c = 1'b0;
    endtask

    task automatic test_kill();
        rdy_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vld_b = 1'b1; rs1_b = DW'(c); rs2_b = 32'd0; tag_b = TW'(30 + c);
            step();
        end
        // Cycle 3: op 30 buffered, ops 31/32 in flight; kill plus a discarded issue.
        n_vec++;
        if (exfin_b !== 1'b1 || otag_b !== 6'd30) begin
            n_err++;
            $display("FAIL kill_pre: exfin=%b tag=%0d, required 1/30", exfin_b, otag_b);
        end
        kill_b = 1'b1; vld_b = 1'b1; tag_b = 6'd33;
        step();
        kill_b = 1'b0; vld_b = 1'b0;
        n_vec++;
        if (inacc_b !== 1'b0) begin
            n_err++;
            $display("FAIL kill_inacc: inacc=%b, required 0", inacc_b);
        end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (exfin_b !== 1'b0) begin
                n_err++;
                $display("FAIL kill_stale k%0d: exfin=%b tag=%0d, required exfin 0", k, exfin_b, otag_b);
            end
            step();
        end
        // Credits must restart from zero: three issues leave one credit free.
        for (int c = 0; c < 3; c++) begin
            vld_b = 1'b1; rs1_b = DW'(200 + c); rs2_b = 32'd0; tag_b = TW'(40 + c);
            step();
        end
        vld_b = 1'b0;
        n_vec++;
        if (inacc_b !== 1'b0 || exfin_b !== 1'b1 || otag_b !== 6'd40 || res_b !== 32'd200) begin
            n_err++;
            $display("FAIL kill_after: inacc=%b exfin=%b tag=%0d res=%0d, required 0/1/40/200",
                     inacc_b, exfin_b, otag_b, res_b);
        end
        kill_b = 1'b1;
        step();
        kill_b = 1'b0; rdy_b = 1'b1;
    endtask

    task automatic test_reset_mid();
        rdy_a = 1'b0;
        op_a = 4'd0; s1_a = 2'd0; s2_a = 2'd0;
        rs1_a = 32'h1; rs2_a = 32'h2; tag_a = 6'd9; vld_a = 1'b1;
        step();
        n_vec++;
        if (exfin_a !== 1'b1 || res_a !== 32'h3) begin
            n_err++;
            $display("FAIL rstmid_pre: exfin=%b res=%h, required 1/3", exfin_a, res_a);
        end
        rst_n = 1'b0; tag_a = 6'd10;
        step();
        rst_n = 1'b1; vld_a = 1'b0;
        n_vec++;
        if ({exfin_a, inacc_a, res_a, otag_a} !== '0) begin
            n_err++;
            $display("FAIL rstmid_clear: exfin=%b inacc=%b res=%h tag=%h, required all 0",
                     exfin_a, inacc_a, res_a, otag_a);
        end
        rdy_a = 1'b1;
        rs1_a = 32'h11; rs2_a = 32'h22; tag_a = 6'd7; vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        n_vec++;
        if (exfin_a !== 1'b1 || res_a !== 32'h33 || otag_a !== 6'd7) begin
            n_err++;
            $display("FAIL rstmid_fresh: exfin=%b res=%h tag=%0d, required 1/33/7",
                     exfin_a, res_a, otag_a);
        end
        step();
        n_vec++;
        if (exfin_a !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_drain: exfin=%b, required 0", exfin_a);
        end
    endtask

    initial begin
        vld_a = 0; kill_a = 0; rdy_a = 1; op_a = 0; s1_a = 0; s2_a = 0;
        rs1_a = 0; pc_a = 0; rs2_a = 0; imm_a = 0; tag_a = 0;
        vld_b = 0; kill_b = 0; rdy_b = 1; rs1_b = 0; rs2_b = 0; tag_b = 0;
        vld_c = 0; rdy_c = 1; rs1_c = 0; rs2_c = 0; tag_c = 0;
        test_reset();
        test_single_add();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_kill();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
